// File: rtl/m_axis_cq_adapt_xn.sv
// rtl/m_axis_cq_adapt_xn.sv - UltraScale CQ descriptor stream to PCIe TLP adapter
module m_axis_cq_adapt_xn #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  user_clk,
   input  logic                  user_reset,
   input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata_a,
   input  logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep_a,
   input  logic                  m_axis_cq_tlast_a,
   output logic [3:0]            m_axis_cq_tready_a,
   input  logic [84:0]           m_axis_cq_tuser_a,
   input  logic                  m_axis_cq_tvalid_a,
   output logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep,
   output logic                  m_axis_cq_tlast,
   input  logic                  m_axis_cq_tready,
   output logic [9:0]            m_axis_cq_tuser,
   output logic                  m_axis_cq_tvalid
);
   localparam int N = DATA_WIDTH / 32;
   localparam logic [11:0] NMASK = 12'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PASS, S_FLUSH} state_t;

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] hold_q, hold_n;
   logic [127:0]          hdr_q, hdr_n;
   logic                  h4_q, h4_n, flush_q, flush_n, first_q, first_n, disc_q, disc_n;
   logic [7:0]            bar_q, bar_n;
   logic [KEEP_WIDTH-1:0] lkeep_q, lkeep_n;
   logic                  o_valid, o_valid_n, o_last, o_last_n;
   logic [DATA_WIDTH-1:0] o_data, o_data_n, shifted;
   logic [KEEP_WIDTH-1:0] o_keep, o_keep_n;
   logic [9:0]            o_user, o_user_n;

   logic [31:0]           dw0_in, dw1_in, dw2_in, dw3_in, dw0_hdr, dw1_hdr, dw2_hdr, dw3_hdr;
   logic [127:0]          hdr_in;
   logic [10:0]           len_in;
   logic [11:0]           lsum_in, fsum_in;
   logic [KEEP_WIDTH-1:0] lkeep_in;
   logic [7:0]            bar_in;
   logic [4:0]            type_in;
   logic                  wr_in, h4_in, flush_in, sop_in, disc_in;
   logic                  adv, ready, acc;
   logic                  unused_bits;

   // Byte keep with the lowest r dwords enabled
   function automatic logic [KEEP_WIDTH-1:0] dw_keep(input logic [11:0] r);
      logic [KEEP_WIDTH-1:0] k;
      k = '0;
      for (int i = 0; i < N; i++)
         if (12'(i) < r) k[4*i +: 4] = 4'hF;
      return k;
   endfunction

   // Overlay the 3 or 4 header dwords onto the low end of a beat
   function automatic logic [DATA_WIDTH-1:0] with_hdr(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [127:0] h, input logic four);
      logic [DATA_WIDTH-1:0] r;
      r = d;
      r[95:0] = h[95:0];
      if (four) r[127:96] = h[127:96];
      return r;
   endfunction

   assign dw0_in  = m_axis_cq_tdata_a[31:0];
   assign dw1_in  = m_axis_cq_tdata_a[63:32];
   assign dw2_in  = m_axis_cq_tdata_a[95:64];
   assign dw3_in  = m_axis_cq_tdata_a[127:96];
   assign sop_in  = m_axis_cq_tuser_a[40];
   assign disc_in = m_axis_cq_tuser_a[41];

   assign len_in   = (dw2_in[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw2_in[9:0]};
   assign h4_in    = |dw1_in;
   assign lsum_in  = {1'b0, len_in} + (h4_in ? 12'd3 : 12'd2);
   assign lkeep_in = dw_keep((lsum_in & NMASK) + 12'd1);
   // A 3DW write needs a trailing flush beat unless H+len fills the last beat exactly
   assign fsum_in  = {1'b0, len_in} + 12'd3;
   assign flush_in = (fsum_in & NMASK) != 12'd0;
   assign bar_in   = 8'd1 << dw3_in[18:16];

   assign dw0_hdr = {1'b0, wr_in, h4_in, type_in, 1'b0, dw3_in[27:25], 4'b0000, 1'b0, 1'b0,
                     dw3_in[29:28], 2'b00, dw2_in[9:0]};
   assign dw1_hdr = {dw2_in[31:16], dw3_in[7:0], m_axis_cq_tuser_a[7:4], m_axis_cq_tuser_a[3:0]};
   assign dw2_hdr = h4_in ? dw1_in : {dw0_in[31:2], 2'b00};
   assign dw3_hdr = {dw0_in[31:2], 2'b00};
   assign hdr_in  = {dw3_hdr, dw2_hdr, dw1_hdr, dw0_hdr};

   assign adv                = !o_valid | m_axis_cq_tready;
   assign ready              = adv & (state != S_FLUSH);
   assign acc                = m_axis_cq_tvalid_a & ready;
   assign m_axis_cq_tready_a = {4{ready}};

   assign unused_bits = ^{m_axis_cq_tkeep_a, m_axis_cq_tuser_a[84:42], m_axis_cq_tuser_a[39:8],
                          dw2_in[15], dw2_in[10], dw3_in[31:30], dw3_in[24:19], dw3_in[15:8]};

   // Map the CQ request code onto TLP write flag and type field
   always_comb begin
      wr_in   = 1'b0;
      type_in = 5'b00000;
      case (dw2_in[14:11])
         4'b0111: type_in = 5'b00001;
         4'b0001: wr_in = 1'b1;
         4'b0010: type_in = 5'b00010;
         4'b0011: begin wr_in = 1'b1; type_in = 5'b00010; end
         4'b1000: type_in = 5'b00100;
         4'b1010: begin wr_in = 1'b1; type_in = 5'b00100; end
         4'b1001: type_in = 5'b00101;
         4'b1011: begin wr_in = 1'b1; type_in = 5'b00101; end
         default: ;
      endcase
   end

   // Next state and next output-register contents
   always_comb begin
      state_n   = state;
      hold_n    = hold_q;
      hdr_n     = hdr_q;
      h4_n      = h4_q;
      bar_n     = bar_q;
      lkeep_n   = lkeep_q;
      flush_n   = flush_q;
      first_n   = first_q;
      disc_n    = disc_q;
      o_valid_n = o_valid;
      o_data_n  = o_data;
      o_keep_n  = o_keep;
      o_last_n  = o_last;
      o_user_n  = o_user;
      shifted   = {dw0_in, hold_q[DATA_WIDTH-1:32]};
      if (adv) begin
         o_valid_n = 1'b0;
         case (state)
            S_IDLE: if (acc && sop_in) begin
               hdr_n   = hdr_in;
               h4_n    = h4_in;
               bar_n   = bar_in;
               lkeep_n = lkeep_in;
               flush_n = flush_in;
               disc_n  = disc_in;
               first_n = 1'b1;
               if (!wr_in) begin
                  o_valid_n = 1'b1;
                  o_data_n  = with_hdr('0, hdr_in, h4_in);
                  o_keep_n  = dw_keep(h4_in ? 12'd4 : 12'd3);
                  o_last_n  = 1'b1;
                  o_user_n  = {h4_in, disc_in, bar_in};
               end else if (h4_in) begin
                  o_valid_n = 1'b1;
                  o_data_n  = with_hdr(m_axis_cq_tdata_a, hdr_in, 1'b1);
                  o_keep_n  = m_axis_cq_tlast_a ? lkeep_in : '1;
                  o_last_n  = m_axis_cq_tlast_a;
                  o_user_n  = {1'b1, m_axis_cq_tlast_a & disc_in, bar_in};
                  if (!m_axis_cq_tlast_a) state_n = S_PASS;
               end else begin
                  hold_n  = m_axis_cq_tdata_a;
                  state_n = m_axis_cq_tlast_a ? S_FLUSH : S_HOLD;
               end
            end
            S_HOLD: if (acc) begin
               o_valid_n = 1'b1;
               o_data_n  = first_q ? with_hdr(shifted, hdr_q, 1'b0) : shifted;
               o_keep_n  = '1;
               o_last_n  = 1'b0;
               o_user_n  = {h4_q, 1'b0, bar_q};
               first_n   = 1'b0;
               hold_n    = m_axis_cq_tdata_a;
               disc_n    = disc_q | disc_in;
               if (m_axis_cq_tlast_a) begin
                  if (flush_q) begin
                     state_n = S_FLUSH;
                  end else begin
                     o_last_n    = 1'b1;
                     o_keep_n    = lkeep_q;
                     o_user_n[8] = disc_q | disc_in;
                     state_n     = S_IDLE;
                  end
               end
            end
            S_PASS: if (acc) begin
               o_valid_n = 1'b1;
               o_data_n  = m_axis_cq_tdata_a;
               o_keep_n  = m_axis_cq_tlast_a ? lkeep_q : '1;
               o_last_n  = m_axis_cq_tlast_a;
               o_user_n  = {h4_q, m_axis_cq_tlast_a & (disc_q | disc_in), bar_q};
               disc_n    = disc_q | disc_in;
               if (m_axis_cq_tlast_a) state_n = S_IDLE;
            end
            S_FLUSH: begin
               shifted   = {32'd0, hold_q[DATA_WIDTH-1:32]};
               o_valid_n = 1'b1;
               o_data_n  = first_q ? with_hdr(shifted, hdr_q, 1'b0) : shifted;
               o_keep_n  = lkeep_q;
               o_last_n  = 1'b1;
               o_user_n  = {h4_q, disc_q, bar_q};
               first_n   = 1'b0;
               state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State, per-packet context and registered output stage
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state   <= S_IDLE;
         hold_q  <= '0;
         hdr_q   <= '0;
         h4_q    <= 1'b0;
         bar_q   <= '0;
         lkeep_q <= '0;
         flush_q <= 1'b0;
         first_q <= 1'b0;
         disc_q  <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_keep  <= '0;
         o_last  <= 1'b0;
         o_user  <= '0;
      end else begin
         state   <= state_n;
         hold_q  <= hold_n;
         hdr_q   <= hdr_n;
         h4_q    <= h4_n;
         bar_q   <= bar_n;
         lkeep_q <= lkeep_n;
         flush_q <= flush_n;
         first_q <= first_n;
         disc_q  <= disc_n;
         o_valid <= o_valid_n;
         o_data  <= o_data_n;
         o_keep  <= o_keep_n;
         o_last  <= o_last_n;
         o_user  <= o_user_n;
      end
   end

   assign m_axis_cq_tvalid = o_valid;
   assign m_axis_cq_tdata  = o_data;
   assign m_axis_cq_tkeep  = o_keep;
   assign m_axis_cq_tlast  = o_last;
   assign m_axis_cq_tuser  = o_user;
endmodule

// File: tb/tb_m_axis_cq_adapt_xn.sv
// tb/tb_m_axis_cq_adapt_xn.sv - directed bench for the CQ adapter at 128 and 256 bits
module tb_m_axis_cq_adapt_xn;
   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic [9:0]   user;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst, sel, gaps, tlast_a, tvalid_a, tready, v128, v256;
   logic [255:0] tdata_a;
   logic [84:0]  tuser_a;
   logic [15:0]  keep_a128 = '1;
   logic [31:0]  keep_a256 = '1;
   logic [3:0]   r128, r256;
   logic [127:0] o128_data;
   logic [255:0] o256_data;
   logic [15:0]  o128_keep;
   logic [31:0]  o256_keep;
   logic [9:0]   o128_user, o256_user;
   logic         o128_last, o128_valid, o256_last, o256_valid;

   logic [31:0]  pkt[$];
   beat_t        q128[$], q256[$];
   int           vectors = 0, miscompares = 0;

   assign v128 = tvalid_a & ~sel;
   assign v256 = tvalid_a & sel;

   m_axis_cq_adapt_xn #(.DATA_WIDTH(128)) dut128 (
      .user_clk(clk), .user_reset(rst),
      .m_axis_cq_tdata_a(tdata_a[127:0]), .m_axis_cq_tkeep_a(keep_a128),
      .m_axis_cq_tlast_a(tlast_a), .m_axis_cq_tready_a(r128),
      .m_axis_cq_tuser_a(tuser_a), .m_axis_cq_tvalid_a(v128),
      .m_axis_cq_tdata(o128_data), .m_axis_cq_tkeep(o128_keep),
      .m_axis_cq_tlast(o128_last), .m_axis_cq_tready(tready),
      .m_axis_cq_tuser(o128_user), .m_axis_cq_tvalid(o128_valid));

   m_axis_cq_adapt_xn #(.DATA_WIDTH(256)) dut256 (
      .user_clk(clk), .user_reset(rst),
      .m_axis_cq_tdata_a(tdata_a), .m_axis_cq_tkeep_a(keep_a256),
      .m_axis_cq_tlast_a(tlast_a), .m_axis_cq_tready_a(r256),
      .m_axis_cq_tuser_a(tuser_a), .m_axis_cq_tvalid_a(v256),
      .m_axis_cq_tdata(o256_data), .m_axis_cq_tkeep(o256_keep),
      .m_axis_cq_tlast(o256_last), .m_axis_cq_tready(tready),
      .m_axis_cq_tuser(o256_user), .m_axis_cq_tvalid(o256_valid));

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   // Core-side ready, optionally with random gaps
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Collect every output beat transferred at the following edge
   initial forever begin
      beat_t m;
      @(negedge clk);
      if (o128_valid && tready) begin
         m.data = {128'd0, o128_data}; m.keep = {16'd0, o128_keep};
         m.last = o128_last; m.user = o128_user;
         q128.push_back(m);
      end
      if (o256_valid && tready) begin
         m.data = o256_data; m.keep = o256_keep;
         m.last = o256_last; m.user = o256_user;
         q256.push_back(m);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mk_desc(input logic [31:0] alo, input logic [31:0] ahi, input logic [3:0] rt,
                          input logic [9:0] len, input logic [15:0] reqid, input logic [7:0] tag,
                          input logic [2:0] bar);
      pkt.delete();
      pkt.push_back(alo);
      pkt.push_back(ahi);
      pkt.push_back({reqid, 1'b0, rt, 1'b0, len});
      pkt.push_back({2'b00, 2'b00, 3'b000, 6'd0, bar, 8'd0, tag});
   endtask

   task automatic put_beat(input logic s, input logic [255:0] d, input logic sop, input logic last,
                           input logic disc, input logic [3:0] fbe, input logic [3:0] lbe);
      int t;
      sel = s; tdata_a = d; tlast_a = last; tvalid_a = 1'b1;
      tuser_a = '0;
      tuser_a[3:0] = fbe; tuser_a[7:4] = lbe; tuser_a[40] = sop; tuser_a[41] = disc;
      t = 0;
      @(negedge clk);
      while (!(s ? r256[0] : r128[0]) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("accept_bound", 32'(t < 200), 32'd1);
      @(posedge clk);
      #1;
      tvalid_a = 1'b0; tlast_a = 1'b0; tuser_a = '0;
   endtask

   task automatic send_pkt(input logic s, input logic [3:0] fbe, input logic [3:0] lbe,
                           input int disc_beat, input int max_beats);
      int n, nb;
      logic [255:0] d;
      n  = s ? 8 : 4;
      nb = (pkt.size() + n - 1) / n;
      @(posedge clk);
      #1;
      for (int b = 0; b < nb && b < max_beats; b++) begin
         d = '0;
         for (int j = 0; j < n; j++)
            if (b * n + j < pkt.size()) d[32*j +: 32] = pkt[b * n + j];
         put_beat(s, d, b == 0, b == nb - 1, b == disc_beat, fbe, lbe);
      end
   endtask

   task automatic wait_beats(input logic s, input int cnt, input string tag);
      int t;
      t = 0;
      while ((s ? q256.size() : q128.size()) < cnt && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk(tag, 32'(s ? q256.size() : q128.size()), 32'(cnt));
   endtask

   task automatic pop(input logic s, output beat_t b);
      b.data = '0; b.keep = '0; b.last = 1'b0; b.user = '0;
      if (s) begin
         if (q256.size() > 0) b = q256.pop_front();
      end else if (q128.size() > 0) begin
         b = q128.pop_front();
      end
   endtask

   task automatic check_t5(input string p);
      beat_t b;
      wait_beats(1'b1, 2, {p, "_count"});
      pop(1'b1, b);
      chk({p, "_b0_dw0"}, b.data[31:0], 32'h40000008);
      chk({p, "_b0_dw1"}, b.data[63:32], 32'h010044FF);
      chk({p, "_b0_dw2"}, b.data[95:64], 32'h00004000);
      for (int i = 3; i < 8; i++)
         chk({p, "_b0_pay"}, b.data[32*i +: 32], 32'h33330000 + 32'(i - 3));
      chk({p, "_b0_keep"}, b.keep, 32'hFFFFFFFF);
      chk({p, "_b0_last"}, 32'(b.last), 32'd0);
      chk({p, "_b0_user"}, 32'(b.user), 32'h004);
      pop(1'b1, b);
      for (int i = 0; i < 3; i++)
         chk({p, "_b1_pay"}, b.data[32*i +: 32], 32'h33330005 + 32'(i));
      chk({p, "_b1_keep"}, b.keep, 32'h00000FFF);
      chk({p, "_b1_last"}, 32'(b.last), 32'd1);
      chk({p, "_b1_user"}, 32'(b.user), 32'h004);
   endtask

   initial begin
      beat_t bt;
      rst = 1'b1; sel = 1'b0; gaps = 1'b0; tdata_a = '0; tlast_a = 1'b0;
      tvalid_a = 1'b0; tuser_a = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 32'(o128_valid), 32'd0);
      chk("rst_tlast", 32'(o128_last), 32'd0);
      chk("rst_tkeep", 32'(o128_keep), 32'd0);
      chk("rst_tuser", 32'(o128_user), 32'd0);
      chk("rst_tready_a", 32'(r128), 32'hF);
      chk("rst_tvalid256", 32'(o256_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 128-bit MemRd, 3DW header only
      mk_desc(32'h10000010, 32'h0, 4'b0000, 10'd1, 16'h0100, 8'h5A, 3'd0);
      send_pkt(1'b0, 4'hF, 4'h0, -1, 99);
      wait_beats(1'b0, 1, "t1_count");
      pop(1'b0, bt);
      chk("t1_dw0", bt.data[31:0], 32'h00000001);
      chk("t1_dw1", bt.data[63:32], 32'h01005A0F);
      chk("t1_dw2", bt.data[95:64], 32'h10000010);
      chk("t1_keep", bt.keep, 32'h00000FFF);
      chk("t1_last", 32'(bt.last), 32'd1);
      chk("t1_user", 32'(bt.user), 32'h001);

      // 128-bit MemWr 3DW, len 1: single output beat, no flush
      mk_desc(32'h00002000, 32'h0, 4'b0001, 10'd1, 16'h0100, 8'h11, 3'd0);
      pkt.push_back(32'hCAFEF00D);
      send_pkt(1'b0, 4'hF, 4'h0, -1, 99);
      wait_beats(1'b0, 1, "t2_count");
      pop(1'b0, bt);
      chk("t2_dw0", bt.data[31:0], 32'h40000001);
      chk("t2_dw1", bt.data[63:32], 32'h0100110F);
      chk("t2_dw2", bt.data[95:64], 32'h00002000);
      chk("t2_dw3", bt.data[127:96], 32'hCAFEF00D);
      chk("t2_keep", bt.keep, 32'h0000FFFF);
      chk("t2_last", 32'(bt.last), 32'd1);

      // 128-bit MemWr 3DW, len 4: flush beat carries 3 dwords
      mk_desc(32'h00003000, 32'h0, 4'b0001, 10'd4, 16'h0100, 8'h22, 3'd0);
      for (int i = 0; i < 4; i++) pkt.push_back(32'h11110000 + 32'(i));
      send_pkt(1'b0, 4'hF, 4'hF, -1, 99);
      wait_beats(1'b0, 2, "t3_count");
      pop(1'b0, bt);
      chk("t3_b0_dw0", bt.data[31:0], 32'h40000004);
      chk("t3_b0_dw1", bt.data[63:32], 32'h010022FF);
      chk("t3_b0_dw3", bt.data[127:96], 32'h11110000);
      chk("t3_b0_last", 32'(bt.last), 32'd0);
      pop(1'b0, bt);
      chk("t3_b1_dw0", bt.data[31:0], 32'h11110001);
      chk("t3_b1_dw1", bt.data[63:32], 32'h11110002);
      chk("t3_b1_dw2", bt.data[95:64], 32'h11110003);
      chk("t3_b1_keep", bt.keep, 32'h00000FFF);
      chk("t3_b1_last", 32'(bt.last), 32'd1);

      // 128-bit MemWr 4DW (64-bit address), len 2
      mk_desc(32'h00000000, 32'h00000001, 4'b0001, 10'd2, 16'h0100, 8'h33, 3'd0);
      pkt.push_back(32'h22220000);
      pkt.push_back(32'h22220001);
      send_pkt(1'b0, 4'hF, 4'hF, -1, 99);
      wait_beats(1'b0, 2, "t4_count");
      pop(1'b0, bt);
      chk("t4_b0_dw0", bt.data[31:0], 32'h60000002);
      chk("t4_b0_dw1", bt.data[63:32], 32'h010033FF);
      chk("t4_b0_dw2", bt.data[95:64], 32'h00000001);
      chk("t4_b0_dw3", bt.data[127:96], 32'h00000000);
      chk("t4_b0_keep", bt.keep, 32'h0000FFFF);
      chk("t4_b0_user", 32'(bt.user), 32'h201);
      pop(1'b0, bt);
      chk("t4_b1_dw0", bt.data[31:0], 32'h22220000);
      chk("t4_b1_dw1", bt.data[63:32], 32'h22220001);
      chk("t4_b1_keep", bt.keep, 32'h000000FF);
      chk("t4_b1_last", 32'(bt.last), 32'd1);
      chk("t4_b1_user", 32'(bt.user), 32'h201);

      // 256-bit MemWr 3DW, len 8, BAR 2; then again under core back-pressure
      mk_desc(32'h00004000, 32'h0, 4'b0001, 10'd8, 16'h0100, 8'h44, 3'd2);
      for (int i = 0; i < 8; i++) pkt.push_back(32'h33330000 + 32'(i));
      send_pkt(1'b1, 4'hF, 4'hF, -1, 99);
      check_t5("t5");
      gaps = 1'b1;
      send_pkt(1'b1, 4'hF, 4'hF, -1, 99);
      check_t5("t5gap");
      gaps = 1'b0;

      // Discontinue on input beat 1 of a 4-beat write
      mk_desc(32'h00005000, 32'h0, 4'b0001, 10'd12, 16'h0100, 8'h55, 3'd0);
      for (int i = 0; i < 12; i++) pkt.push_back(32'h44440000 + 32'(i));
      send_pkt(1'b0, 4'hF, 4'hF, 1, 99);
      wait_beats(1'b0, 4, "t6_count");
      pop(1'b0, bt);
      chk("t6_b0_user", 32'(bt.user), 32'h001);
      pop(1'b0, bt);
      chk("t6_b1_dw0", bt.data[31:0], 32'h44440001);
      chk("t6_b1_user", 32'(bt.user), 32'h001);
      pop(1'b0, bt);
      chk("t6_b2_user", 32'(bt.user), 32'h001);
      pop(1'b0, bt);
      chk("t6_b3_dw0", bt.data[31:0], 32'h44440009);
      chk("t6_b3_dw2", bt.data[95:64], 32'h4444000B);
      chk("t6_b3_keep", bt.keep, 32'h00000FFF);
      chk("t6_b3_last", 32'(bt.last), 32'd1);
      chk("t6_b3_user", 32'(bt.user), 32'h101);

      // Reset in the middle of a write, then a clean MemRd
      mk_desc(32'h00006000, 32'h0, 4'b0001, 10'd12, 16'h0100, 8'h66, 3'd0);
      for (int i = 0; i < 12; i++) pkt.push_back(32'h55550000 + 32'(i));
      send_pkt(1'b0, 4'hF, 4'hF, -1, 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t7_rst_tvalid", 32'(o128_valid), 32'd0);
      repeat (3) @(negedge clk);
      q128.delete();
      mk_desc(32'h10000020, 32'h0, 4'b0000, 10'd1, 16'h0200, 8'h77, 3'd1);
      send_pkt(1'b0, 4'h3, 4'h0, -1, 99);
      wait_beats(1'b0, 1, "t7_count");
      pop(1'b0, bt);
      chk("t7_dw0", bt.data[31:0], 32'h00000001);
      chk("t7_dw1", bt.data[63:32], 32'h02007703);
      chk("t7_dw2", bt.data[95:64], 32'h10000020);
      chk("t7_keep", bt.keep, 32'h00000FFF);
      chk("t7_user", 32'(bt.user), 32'h002);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
